// File: rtl/fetch_aligner.sv
// Instruction-stream aligner: buffers fetched 32-bit words as halfwords and
// presents whole RV32IC instructions (16- or 32-bit) with their PC.
module fetch_aligner #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    BUF_HALFWORDS = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  fetch_req,
  output logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_ack,
  input  logic [31:0]           fetch_data,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_is_compact
);

  localparam int PTR_W = $clog2(BUF_HALFWORDS);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK   = ~ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] HALF_MASK   = ~ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] RESET_FETCH = RESET_PC & WORD_MASK;
  localparam logic [ADDR_WIDTH-1:0] RESET_HALF  = RESET_PC & HALF_MASK;
  localparam logic                  RESET_DROP  = RESET_PC[1];

  logic [15:0]           buf_r [BUF_HALFWORDS];
  logic [PTR_W-1:0]      head_r;
  logic [PTR_W-1:0]      tail_r;
  logic [CNT_W-1:0]      count_r;
  logic [ADDR_WIDTH-1:0] fetch_ptr_r;
  logic                  drop_low_r;
  logic [ADDR_WIDTH-1:0] pc_r;

  logic [PTR_W-1:0] head_p1_s;
  logic [PTR_W-1:0] tail_p1_s;
  logic [15:0]      hw0_s;
  logic [15:0]      hw1_s;
  logic             compact_s;
  logic             valid_s;
  logic             fetch_req_s;
  logic             push_s;
  logic             pop_s;
  logic [PTR_W-1:0] push_inc_s;
  logic [PTR_W-1:0] pop_inc_s;

  // Head classification, handshake qualification and buffer increments
  always_comb begin
    head_p1_s   = head_r + PTR_W'(1);
    tail_p1_s   = tail_r + PTR_W'(1);
    hw0_s       = buf_r[head_r];
    hw1_s       = buf_r[head_p1_s];
    compact_s   = (hw0_s[1:0] != 2'b11);
    fetch_req_s = (count_r <= CNT_W'(BUF_HALFWORDS - 2));
    if (compact_s) begin
      valid_s = (count_r >= CNT_W'(1));
    end else begin
      valid_s = (count_r >= CNT_W'(2));
    end
    push_s = fetch_req_s && fetch_ack && !redirect;
    pop_s  = valid_s && instr_ready;
    if (push_s) begin
      push_inc_s = drop_low_r ? PTR_W'(1) : PTR_W'(2);
    end else begin
      push_inc_s = '0;
    end
    if (pop_s) begin
      pop_inc_s = compact_s ? PTR_W'(1) : PTR_W'(2);
    end else begin
      pop_inc_s = '0;
    end
  end

  assign fetch_req        = fetch_req_s;
  assign fetch_addr       = fetch_ptr_r;
  assign instr_valid      = valid_s;
  assign instr_pc         = pc_r;
  assign instr_is_compact = valid_s && compact_s;
  assign instr            = !valid_s ? 32'h0000_0000 :
                            compact_s ? {16'h0000, hw0_s} : {hw1_s, hw0_s};

  // Buffer, pointers and PC; redirect flushes and discards same-cycle push/pop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_HALFWORDS; i++) begin
        buf_r[i] <= 16'h0000;
      end
      head_r      <= '0;
      tail_r      <= '0;
      count_r     <= '0;
      fetch_ptr_r <= RESET_FETCH;
      drop_low_r  <= RESET_DROP;
      pc_r        <= RESET_HALF;
    end else if (redirect) begin
      head_r      <= '0;
      tail_r      <= '0;
      count_r     <= '0;
      fetch_ptr_r <= redirect_pc & WORD_MASK;
      drop_low_r  <= redirect_pc[1];
      pc_r        <= redirect_pc & HALF_MASK;
    end else begin
      if (push_s) begin
        if (drop_low_r) begin
          buf_r[tail_r] <= fetch_data[31:16];
        end else begin
          buf_r[tail_r]    <= fetch_data[15:0];
          buf_r[tail_p1_s] <= fetch_data[31:16];
        end
        fetch_ptr_r <= fetch_ptr_r + ADDR_WIDTH'(4);
        drop_low_r  <= 1'b0;
      end
      if (pop_s) begin
        pc_r <= pc_r + (compact_s ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4));
      end
      tail_r  <= tail_r + push_inc_s;
      head_r  <= head_r + pop_inc_s;
      count_r <= count_r + {1'b0, push_inc_s} - {1'b0, pop_inc_s};
    end
  end

endmodule
